// File: rtl/gesture_pkg.sv
// Shared definitions for the gesture pipeline: frame geometry defaults,
// counter sizing helper and the mask packer state encoding.
package gesture_pkg;

  localparam int WIDTH_DEF  = 320;
  localparam int HEIGHT_DEF = 240;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pack_state_t;

endpackage

// File: rtl/mask_fifo2.sv
// Two-entry byte FIFO; a push into a full FIFO is taken when a pop frees
// the head in the same cycle. Output reads zero while empty.
module mask_fifo2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] dout
);

  logic [7:0] mem [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       do_push;
  logic       do_pop;

  assign full    = (count_reg == 2'd2);
  assign empty   = (count_reg == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/object_mask_packer.sv
// Packs the binarized object stream into mask bytes (bit 0 = earliest pixel),
// tracks frame position and reports per-frame object-pixel totals.
module object_mask_packer
  import gesture_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int CNT_W  = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic             object_image,
  output logic [7:0]       mask_byte,
  output logic             mask_valid,
  input  logic             mask_ready,
  output logic [CNT_W-1:0] obj_count,
  output logic             frame_done,
  output logic             overflow
);

  localparam int COL_W = cnt_width(WIDTH);
  localparam int ROW_W = cnt_width(HEIGHT);

  pack_state_t      state_reg, state_next;
  logic [7:0]       shreg_reg, shreg_base;
  logic [2:0]       bit_idx_reg, bit_idx_base;
  logic [COL_W-1:0] col_reg, col_base;
  logic [ROW_W-1:0] row_reg, row_base;
  logic [CNT_W-1:0] run_cnt_reg, run_cnt_base;
  logic [CNT_W-1:0] obj_count_reg;
  logic             push_pend_reg;
  logic             done_pend_reg;
  logic             frame_done_reg;
  logic             overflow_reg;

  logic accept;
  logic last_col;
  logic last_pix;
  logic clear_base;
  logic pop;
  logic fifo_full;
  logic fifo_empty;

  // A restart, or the cycle after a frame's final pixel, starts from a clean slate.
  assign clear_base = frame_start || done_pend_reg;
  assign accept     = pix_valid && ((state_reg == ACTIVE) || frame_start);
  assign pop        = mask_valid && mask_ready;

  always_comb begin
    shreg_base   = shreg_reg;
    bit_idx_base = bit_idx_reg;
    col_base     = col_reg;
    row_base     = row_reg;
    run_cnt_base = run_cnt_reg;
    if (clear_base) begin
      shreg_base   = '0;
      bit_idx_base = '0;
      col_base     = '0;
      row_base     = '0;
      run_cnt_base = '0;
    end
  end

  assign last_col = (col_base == COL_W'(WIDTH - 1));
  assign last_pix = accept && last_col && (row_base == ROW_W'(HEIGHT - 1));

  always_comb begin
    state_next = state_reg;
    if (frame_start) state_next = ACTIVE;
    if (last_pix)    state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      bit_idx_reg    <= '0;
      col_reg        <= '0;
      row_reg        <= '0;
      run_cnt_reg    <= '0;
      obj_count_reg  <= '0;
      push_pend_reg  <= 1'b0;
      done_pend_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      push_pend_reg  <= accept && (bit_idx_base == 3'd7);
      done_pend_reg  <= last_pix;
      frame_done_reg <= done_pend_reg;
      if (done_pend_reg) obj_count_reg <= run_cnt_reg;
      // The completed byte is offered to the FIFO one cycle after its last pixel.
      if (push_pend_reg && fifo_full && !pop) overflow_reg <= 1'b1;

      shreg_reg   <= shreg_base;
      bit_idx_reg <= bit_idx_base;
      col_reg     <= col_base;
      row_reg     <= row_base;
      run_cnt_reg <= run_cnt_base;
      if (accept) begin
        shreg_reg[bit_idx_base] <= object_image;
        bit_idx_reg             <= bit_idx_base + 3'd1;
        run_cnt_reg             <= run_cnt_base + CNT_W'(object_image);
        if (last_col) begin
          col_reg <= '0;
          row_reg <= row_base + ROW_W'(1);
        end else begin
          col_reg <= col_base + COL_W'(1);
        end
      end
    end
  end

  mask_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_pend_reg),
    .din   (shreg_reg),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (mask_byte)
  );

  assign mask_valid = !fifo_empty;
  assign obj_count  = obj_count_reg;
  assign frame_done = frame_done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_object_mask_packer.sv
// Directed bench for object_mask_packer on a 16x2 frame.
module tb_object_mask_packer;

  localparam int WIDTH  = 16;
  localparam int HEIGHT = 2;
  localparam int CNT_W  = 17;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             frame_start = 1'b0;
  logic             pix_valid = 1'b0;
  logic             object_image = 1'b0;
  logic [7:0]       mask_byte;
  logic             mask_valid;
  logic             mask_ready = 1'b1;
  logic [CNT_W-1:0] obj_count;
  logic             frame_done;
  logic             overflow;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [7:0] got_q[$];

  object_mask_packer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .object_image (object_image),
    .mask_byte    (mask_byte),
    .mask_valid   (mask_valid),
    .mask_ready   (mask_ready),
    .obj_count    (obj_count),
    .frame_done   (frame_done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Record every accepted byte and every frame_done pulse.
  always @(posedge clk) begin
    if (mask_valid && mask_ready) got_q.push_back(mask_byte);
    if (frame_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Send n pixels, LSB first; frame_start optionally rides on the first one.
  task automatic send_bits(input logic [31:0] bits, input int n, input logic fs_first);
    for (int i = 0; i < n; i++) begin
      frame_start  = fs_first && (i == 0);
      pix_valid    = 1'b1;
      object_image = bits[i];
      tick();
    end
    frame_start  = 1'b0;
    pix_valid    = 1'b0;
    object_image = 1'b0;
  endtask

  int done_snap;

  initial begin
    // Reset state
    tick(); tick();
    check("rst_valid", 32'(mask_valid), 0);
    check("rst_byte", 32'(mask_byte), 0);
    check("rst_count", 32'(obj_count), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    tick();

    // Basic pack: 1,0,1,1,0,0,0,1 -> 8'h8D, one cycle after 8th pixel
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    send_bits(32'h8D, 8, 1'b0);
    check("basic_latency", 32'(mask_valid), 0);
    tick();
    check("basic_valid", 32'(mask_valid), 1);
    check("basic_byte", 32'(mask_byte), 32'h8D);
    tick();
    check("basic_popped", 32'(mask_valid), 0);

    // Restart after 5 pixels: partial byte dropped, no frame_done
    got_q.delete();
    done_snap = done_cnt;
    send_bits(32'h1F, 5, 1'b0);
    send_bits(32'h3C, 8, 1'b1);
    tick(); tick();
    check("restart_nbytes", got_q.size(), 1);
    for (int i = 0; i < got_q.size(); i++) check("restart_byte", 32'(got_q[i]), 32'h3C);
    check("restart_nodone", done_cnt, done_snap);

    // Full frame of ones: 4 x FF, obj_count 32
    got_q.delete();
    send_bits(32'hFFFF_FFFF, 32, 1'b1);
    check("frame1_done_early", 32'(frame_done), 0);
    tick();
    check("frame1_done", 32'(frame_done), 1);
    check("frame1_count", 32'(obj_count), 32);
    check("frame1_last_valid", 32'(mask_valid), 1);
    tick();
    check("frame1_done_pulse", 32'(frame_done), 0);
    check("frame1_nbytes", got_q.size(), 4);
    for (int i = 0; i < got_q.size(); i++) check("frame1_byte", 32'(got_q[i]), 32'hFF);

    // Second frame of zeros
    got_q.delete();
    send_bits(32'h0, 32, 1'b1);
    tick();
    check("frame2_done", 32'(frame_done), 1);
    check("frame2_count", 32'(obj_count), 0);
    tick();
    check("frame2_nbytes", got_q.size(), 4);
    for (int i = 0; i < got_q.size(); i++) check("frame2_byte", 32'(got_q[i]), 32'h00);

    // Backpressure: 3 x A5 with ready low, third byte dropped
    got_q.delete();
    mask_ready = 1'b0;
    send_bits(32'hA5A5A5, 24, 1'b1);
    check("bp_ovf_before", 32'(overflow), 0);
    check("bp_hold_byte", 32'(mask_byte), 32'hA5);
    tick();
    check("bp_ovf_set", 32'(overflow), 1);
    check("bp_valid", 32'(mask_valid), 1);
    tick();
    check("bp_stable", 32'(mask_byte), 32'hA5);
    mask_ready = 1'b1;
    tick(); tick();
    check("bp_drained", 32'(mask_valid), 0);
    check("bp_nbytes", got_q.size(), 2);
    for (int i = 0; i < got_q.size(); i++) check("bp_byte", 32'(got_q[i]), 32'hA5);
    check("bp_ovf_sticky", 32'(overflow), 1);

    // Reset mid-frame with a byte queued
    mask_ready = 1'b0;
    send_bits(32'h5A, 8, 1'b1);
    tick();
    check("mid_queued", 32'(mask_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(mask_valid), 0);
    check("mid_rst_byte", 32'(mask_byte), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    check("mid_rst_count", 32'(obj_count), 0);
    check("mid_rst_done", 32'(frame_done), 0);
    done_snap = done_cnt;
    send_bits(32'hFFFF, 16, 1'b0);
    tick(); tick();
    check("nostart_valid", 32'(mask_valid), 0);
    check("nostart_done", done_cnt, done_snap);

    // Push+pop on full FIFO
    got_q.delete();
    send_bits(32'h332211, 24, 1'b1);
    check("pp_full_head", 32'(mask_byte), 32'h11);
    mask_ready = 1'b1;
    tick();
    check("pp_no_ovf", 32'(overflow), 0);
    check("pp_head2", 32'(mask_byte), 32'h22);
    tick();
    check("pp_head3", 32'(mask_byte), 32'h33);
    tick();
    check("pp_empty", 32'(mask_valid), 0);
    check("pp_nbytes", got_q.size(), 3);
    for (int i = 0; i < got_q.size(); i++) check("pp_order", 32'(got_q[i]), 32'h11 * (i + 1));
    check("pp_ovf_final", 32'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/object_mask_packer.md
# object_mask_packer

Consumer end of the background-difference stage. It accepts the 1-bit `object_image` stream, one bit per pixel, in raster order, and packs 8 consecutive pixels into one mask byte. Bytes are offered downstream over a valid/ready handshake through a 2-entry buffer. The block also tracks row and column position, counts object pixels per frame, and reports frame completion and buffer overflow to the gesture-recognition back end.

## Interface
Parameters:
- `WIDTH`, 320: pixels per row. Must be a multiple of 8 and at least 8.
- `HEIGHT`, 240: rows per frame. Must be at least 1.
- `CNT_W`, 17: width of the object-pixel counter. Must hold `WIDTH*HEIGHT`.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse marking the start of a frame. It can coincide with the frame's first `pix_valid`.
- `pix_valid` in 1: `object_image` holds a valid pixel this cycle.
- `object_image` in 1: binarized pixel; 1 = object.
- `mask_byte` out 8: packed pixels. Bit 0 is the earliest pixel.
- `mask_valid` out 1: `mask_byte` is valid.
- `mask_ready` in 1: downstream accepts the byte.
- `obj_count` out CNT_W: object-pixel total for the last completed frame.
- `frame_done` out 1: one-cycle pulse; `obj_count` has just been updated.
- `overflow` out 1: sticky flag, set when a completed byte is dropped.

## Operation
- **States**
  - IDLE: pixels are ignored until `frame_start` is seen.
  - ACTIVE: the frame is being packed.
  - The state returns to IDLE after the final pixel (col = `WIDTH-1`, row = `HEIGHT-1`).
- **Pixel accept:** in ACTIVE, each `pix_valid` does the following.
  - Shifts `object_image` into `shreg[bit_idx]`.
  - Increments `bit_idx`, which is 3 bits and wraps.
  - Increments `col`. `col` wraps at `WIDTH-1`; on wrap, `row` increments.
  - Adds the pixel to the running object count (`run_cnt`) when `object_image` = 1.
- **Byte completion:** when `bit_idx` = 7 and a pixel is accepted, the full byte (including that pixel) is written to the 2-entry FIFO.
  - If the FIFO is full and no pop occurs the same cycle, the byte is dropped and `overflow` is set.
  - A simultaneous push and pop on a full FIFO succeeds.
- **Frame end:** after the final pixel, the next cycle does the following.
  - `obj_count` ← final `run_cnt`, including the last pixel.
  - `frame_done` pulses for one cycle.
  - `run_cnt`, `row`, `col` and `bit_idx` clear.
- **`frame_start` while ACTIVE (restart):**
  - Clears `shreg`, `bit_idx`, `row`, `col` and `run_cnt`.
  - The partial byte is discarded and `frame_done` does not pulse.
  - FIFO contents are kept.
  - If the same cycle carries `pix_valid`, that pixel is the new frame's pixel 0.
- **Output:**
  - `mask_byte` and `mask_valid` are driven from the FIFO head.
  - A pop occurs when `mask_valid && mask_ready`.
- **Reset values:**
  - Outputs: `mask_byte`=0, `mask_valid`=0, `obj_count`=0, `frame_done`=0, `overflow`=0.
  - Internal: state = IDLE, FIFO empty.
  - Reset mid-frame abandons the frame and flushes the FIFO.
  - `overflow` clears only on `rst`.

## Timing
- **Latency:** the 8th pixel accepted at edge N gives `mask_valid`=1 after edge N+1 when the FIFO was empty. Pixel-to-output latency is 1 cycle.
- **Throughput:** 1 pixel per cycle. A ready-held consumer sees at most 1 byte per 8 cycles.
- **Handshake rules:**
  - `mask_byte` stays stable while `mask_valid && !mask_ready`.
  - `mask_valid` never drops without a pop.
- **Frame end:** `frame_done` and `obj_count` update 1 cycle after the final pixel is accepted. They coincide with, or precede, the final byte's `mask_valid`.
- **Upstream alignment:** `pix_valid` and `object_image` arrive in the same cycle, aligned to BackgroundDifference's registered output.

## Structure
- **Shared package `gesture_pkg`:**
  - `WIDTH_DEF`, `HEIGHT_DEF`.
  - A `clog2`-based counter width function.
  - Packer state enum {IDLE, ACTIVE}.
- **Sub-module `mask_fifo2`:** 8-bit, 2-entry synchronous FIFO.
  - Ports: push, pop, full, empty, dout.
  - Same-cycle push+pop is legal when full.
- **Top level:** FSM, `shreg`, counters, overflow flag.

## Test plan
1. **Basic pack:** reset, `frame_start`, then 8 pixels 1,0,1,1,0,0,0,1 with `mask_ready`=1 → `mask_byte`=8'h8D, `mask_valid` for 1 cycle, 1 cycle after the 8th pixel.
2. **Full frame:** `WIDTH`=16, `HEIGHT`=2, all pixels 1 → 4 bytes of 8'hFF, `frame_done` pulse, `obj_count`=32. A second frame of all 0 → `obj_count`=0.
3. **Backpressure:** `mask_ready`=0 for 24 pixels of pattern 8'hA5 → 2 bytes held stable. The third byte is dropped and `overflow`=1. Raising ready drains 8'hA5 twice. `overflow` stays 1 until `rst`.
4. **Push+pop on full:** FIFO full, `mask_ready`=1 on the cycle a byte completes → no overflow and byte order preserved.
5. **Restart:** `frame_start` after 5 pixels → partial byte discarded, no `frame_done`. The next 8 pixels form the first byte.
6. **Reset mid-frame:** `rst` with one byte queued → all outputs 0 next cycle. Pixels without `frame_start` produce nothing.
